regfile_8x16_sb: RTL and testbench

REGFILE_8X16_SB -- requirements
Module: regfile_8x16_sb

---
 rtl/regfile_8x16_sb_pkg.sv | 13 +
 rtl/regfile_8x16_sb_if.sv | 29 ++
 rtl/regfile_8x16_sb_onehot_check.sv | 11 +
 rtl/regfile_8x16_sb.sv | 60 ++++++
 tb/tb_regfile_8x16_sb.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/regfile_8x16_sb_pkg.sv
// Shared types and helpers for the 8x16 register file with issue scoreboard.
package regfile_8x16_sb_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NREG_DEF  = 8;

  typedef logic [2:0] reg_idx_t;
  typedef logic [7:0] onehot_t;

  // Non-zero and no more than one bit set.
  function automatic logic is_onehot(onehot_t v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction
endpackage

// File: rtl/regfile_8x16_sb_if.sv
// Write, read, issue and error signals of the register file, grouped as one bus.
interface regfile_8x16_sb_if
  import regfile_8x16_sb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  onehot_t          wr_onehot;
  logic [WIDTH-1:0] wr_data;
  reg_idx_t         rd_addr_a;
  reg_idx_t         rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_pend_a;
  logic             rd_pend_b;
  logic             iss_valid;
  onehot_t          iss_onehot;
  logic             iss_ready;
  logic             wr_err;

  modport master (
    output wr_onehot, wr_data, rd_addr_a, rd_addr_b, iss_valid, iss_onehot,
    input  rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, iss_ready, wr_err
  );

  modport slave (
    input  wr_onehot, wr_data, rd_addr_a, rd_addr_b, iss_valid, iss_onehot,
    output rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, iss_ready, wr_err
  );
endinterface

// File: rtl/regfile_8x16_sb_onehot_check.sv
// Classifies an 8-bit select vector as exactly-one-hot and/or all-zero.
module onehot_check
  import regfile_8x16_sb_pkg::*;
(
  input  onehot_t vec,
  output logic    is_onehot,
  output logic    is_zero
);
  assign is_onehot = regfile_8x16_sb_pkg::is_onehot(vec);
  assign is_zero   = (vec == 8'd0);
endmodule

// File: rtl/regfile_8x16_sb.sv
// 8 x WIDTH register file with one-hot write, two registered read ports with
// write bypass, and a per-register pending scoreboard for issue tracking.
module regfile_8x16_sb
  import regfile_8x16_sb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  regfile_8x16_sb_if.slave  bus
);
  logic [NREG-1:0][WIDTH-1:0] regs, regs_nxt;
  logic [NREG-1:0]            pend, pend_nxt;
  logic                       wr_one, wr_zero, iss_one, iss_zero;
  logic                       wr_legal, wr_multi, iss_ok, iss_fire;
  onehot_t                    wr_clr, iss_set;

  onehot_check u_wr_chk  (.vec(bus.wr_onehot),  .is_onehot(wr_one),  .is_zero(wr_zero));
  onehot_check u_iss_chk (.vec(bus.iss_onehot), .is_onehot(iss_one), .is_zero(iss_zero));

  assign wr_legal = wr_one;
  assign wr_multi = !wr_one && !wr_zero;
  assign wr_clr   = wr_legal ? bus.wr_onehot : 8'd0;
  assign iss_ok   = iss_one && !iss_zero;

  // A pending target still accepts an issue when this cycle's write retires it.
  assign bus.iss_ready = iss_ok && ((pend & bus.iss_onehot & ~wr_clr) == '0);
  assign iss_fire      = bus.iss_valid && bus.iss_ready;
  assign iss_set       = iss_fire ? bus.iss_onehot : 8'd0;

  // Issue set is applied after write clear so it wins on the same register.
  always_comb begin
    regs_nxt = regs;
    for (int i = 0; i < NREG; i++)
      if (wr_clr[i]) regs_nxt[i] = bus.wr_data;
    pend_nxt = (pend & ~wr_clr) | iss_set;
  end

  // Read ports sample next-state values, giving same-edge write visibility.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs          <= '0;
      pend          <= '0;
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_pend_a <= 1'b0;
      bus.rd_pend_b <= 1'b0;
      bus.wr_err    <= 1'b0;
    end else begin
      regs          <= regs_nxt;
      pend          <= pend_nxt;
      bus.rd_data_a <= regs_nxt[bus.rd_addr_a];
      bus.rd_data_b <= regs_nxt[bus.rd_addr_b];
      bus.rd_pend_a <= pend_nxt[bus.rd_addr_a];
      bus.rd_pend_b <= pend_nxt[bus.rd_addr_b];
      bus.wr_err    <= bus.wr_err | wr_multi;
    end
  end
endmodule

// File: tb/tb_regfile_8x16_sb.sv
// Table-driven bench for regfile_8x16_sb: a behavioral model feeds a
// scoreboard queue of expected read-port results, popped one edge later.
module tb_regfile_8x16_sb;
  import regfile_8x16_sb_pkg::*;

  typedef struct {
    onehot_t     woh;
    logic [15:0] wd;
    reg_idx_t    ra;
    reg_idx_t    rb;
    logic        iv;
    onehot_t     ioh;
    logic        rdy;
  } vec_t;

  typedef struct {
    logic [15:0] da;
    logic [15:0] db;
    logic        pa;
    logic        pb;
    logic        err;
  } exp_t;

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] m_reg [8];
  onehot_t     m_pend;
  logic        m_err;
  exp_t        sb [$];
  vec_t        tbl [12];

  regfile_8x16_sb_if #(.WIDTH(16)) bus ();
  regfile_8x16_sb #(.WIDTH(16), .NREG(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_pend = 8'h0;
    m_err  = 1'b0;
    sb.delete();
  endtask

  task automatic drive_idle();
    bus.wr_onehot  = 8'h0;
    bus.wr_data    = 16'h0;
    bus.rd_addr_a  = 3'd0;
    bus.rd_addr_b  = 3'd0;
    bus.iss_valid  = 1'b0;
    bus.iss_onehot = 8'h0;
  endtask

  task automatic step(input vec_t v, input string tag);
    int   cnt;
    logic mrdy;
    exp_t e, g;
    @(negedge clk);
    bus.wr_onehot  = v.woh;
    bus.wr_data    = v.wd;
    bus.rd_addr_a  = v.ra;
    bus.rd_addr_b  = v.rb;
    bus.iss_valid  = v.iv;
    bus.iss_onehot = v.ioh;
    #1;
    chk({tag, ".iss_ready"}, {31'd0, bus.iss_ready}, {31'd0, v.rdy});
    cnt  = $countones(v.woh);
    mrdy = ($countones(v.ioh) == 1) &&
           ((m_pend & v.ioh & ~((cnt == 1) ? v.woh : 8'h0)) == 8'h0);
    for (int i = 0; i < 8; i++)
      if (cnt == 1 && v.woh[i]) m_reg[i] = v.wd;
    if (cnt == 1) m_pend = m_pend & ~v.woh;
    if (v.iv && mrdy) m_pend = m_pend | v.ioh;
    if (cnt > 1) m_err = 1'b1;
    e.da  = m_reg[v.ra];
    e.db  = m_reg[v.rb];
    e.pa  = m_pend[v.ra];
    e.pb  = m_pend[v.rb];
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({tag, ".rd_data_a"}, {16'd0, bus.rd_data_a}, {16'd0, g.da});
    chk({tag, ".rd_data_b"}, {16'd0, bus.rd_data_b}, {16'd0, g.db});
    chk({tag, ".rd_pend_a"}, {31'd0, bus.rd_pend_a}, {31'd0, g.pa});
    chk({tag, ".rd_pend_b"}, {31'd0, bus.rd_pend_b}, {31'd0, g.pb});
    chk({tag, ".wr_err"},    {31'd0, bus.wr_err},    {31'd0, g.err});
  endtask

  task automatic readback_all(input string tag);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v = '{8'h00, 16'h0, 3'(i), 3'(i + 4), 1'b0, 8'h00, 1'b0};
      step(v, $sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    //          woh    wd        ra    rb    iv    ioh    rdy
    tbl[0]  = '{8'h08, 16'h1234, 3'd3, 3'd0, 1'b0, 8'h01, 1'b1}; // write r3, bypass on a
    tbl[1]  = '{8'h00, 16'h0000, 3'd0, 3'd3, 1'b0, 8'h00, 1'b0}; // read r3 on b
    tbl[2]  = '{8'h14, 16'hFFFF, 3'd2, 3'd4, 1'b0, 8'h04, 1'b1}; // multi-hot: no write, err
    tbl[3]  = '{8'h00, 16'h0000, 3'd2, 3'd4, 1'b1, 8'h20, 1'b1}; // issue r5
    tbl[4]  = '{8'h00, 16'h0000, 3'd5, 3'd5, 1'b1, 8'h20, 1'b0}; // r5 busy
    tbl[5]  = '{8'h20, 16'h5555, 3'd5, 3'd3, 1'b0, 8'h20, 1'b1}; // write r5 clears pend
    tbl[6]  = '{8'h00, 16'h0000, 3'd5, 3'd0, 1'b1, 8'h20, 1'b1}; // r5 issuable again
    tbl[7]  = '{8'h00, 16'h0000, 3'd6, 3'd5, 1'b1, 8'h40, 1'b1}; // issue r6
    tbl[8]  = '{8'h40, 16'h6666, 3'd6, 3'd6, 1'b1, 8'h40, 1'b1}; // write+issue r6
    tbl[9]  = '{8'h80, 16'hA5A5, 3'd7, 3'd6, 1'b0, 8'hC0, 1'b0}; // non-pending write
    tbl[10] = '{8'h01, 16'h0001, 3'd0, 3'd1, 1'b1, 8'h03, 1'b0}; // multi-hot issue refused
    tbl[11] = '{8'h00, 16'h0000, 3'd1, 3'd0, 1'b1, 8'h02, 1'b1}; // issue r1

    drive_idle();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.rd_data_a", {16'd0, bus.rd_data_a}, 32'd0);
    chk("rst.rd_data_b", {16'd0, bus.rd_data_b}, 32'd0);
    chk("rst.rd_pend_a", {31'd0, bus.rd_pend_a}, 32'd0);
    chk("rst.rd_pend_b", {31'd0, bus.rd_pend_b}, 32'd0);
    chk("rst.wr_err",    {31'd0, bus.wr_err},    32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.iss_onehot = 8'h01 << i;
      #1;
      chk($sformatf("rst.iss_ready%0d", i), {31'd0, bus.iss_ready}, 32'd1);
    end
    bus.iss_onehot = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    readback_all("init");
    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("err_hold", {31'd0, bus.wr_err}, 32'd1);

    // Reset lands between driving a write+issue to r1 and its clock edge.
    @(negedge clk);
    bus.wr_onehot  = 8'h02;
    bus.wr_data    = 16'hABCD;
    bus.rd_addr_a  = 3'd1;
    bus.rd_addr_b  = 3'd6;
    bus.iss_valid  = 1'b1;
    bus.iss_onehot = 8'h02;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.rd_data_a", {16'd0, bus.rd_data_a}, 32'd0);
    chk("midrst.rd_data_b", {16'd0, bus.rd_data_b}, 32'd0);
    chk("midrst.rd_pend_b", {31'd0, bus.rd_pend_b}, 32'd0);
    chk("midrst.wr_err",    {31'd0, bus.wr_err},    32'd0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    model_reset();
    rst_n = 1'b1;
    readback_all("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
